// File: rtl/scroll_pkg.sv
// Shared constants for the background scroll load controller.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package scroll_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PEND  = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;

   // Bit positions inside the 2-bit ctrl register
   localparam int CTRL_W     = 2;
   localparam int DIR_BIT    = 0;
   localparam int FREEZE_BIT = 1;

   // Counting up is the power-on direction
   localparam logic DIR_RESET = 1'b1;

   // Reset value of a ctrl register: direction up, not frozen
   function automatic logic [CTRL_W-1:0] ctrl_reset_val();
      logic [CTRL_W-1:0] v;
      v             = '0;
      v[DIR_BIT]    = DIR_RESET;
      v[FREEZE_BIT] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/scroll_load_ctrl_edge_det.sv
// Rise/fall detector with a sampling stage and a configurable reset level.
// Latency: an input change sampled at edge e is flagged during the cycle after edge e.
// Backpressure: none; the flags are single-cycle pulses.
module edge_det_sync #(
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic Reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic sampled;
   logic last;

   // Sample the input and keep its previous sample for comparison
   always_ff @(posedge clk) begin
      if (Reset) begin
         sampled <= RESET_LEVEL;
         last    <= RESET_LEVEL;
      end else begin
         sampled <= din;
         last    <= sampled;
      end
   end

   assign rise = sampled & ~last;
   assign fall = ~sampled & last;

endmodule

// File: rtl/scroll_load_ctrl.sv
// Scroll shadow/active registers plus load/enable sequencing for a 4-bit counter chain.
// Latency: hblank fall -> load_n low 2 cycles later; vblank rise -> P updated 2 cycles later.
// Backpressure: none; CPU strobes always land in shadow, the counter chain never stalls us.
module scroll_load_ctrl
   import scroll_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             cen,
   input  logic             hblank,
   input  logic             vblank,
   input  logic [7:0]       cpu_din,
   input  logic             cpu_wr_lo,
   input  logic             cpu_wr_hi,
   input  logic             cpu_wr_ctrl,
   output logic [WIDTH-1:0] P,
   output logic             load_n,
   output logic             enp_n,
   output logic             ent_n,
   output logic             direction
);

   logic cen_rise;
   logic hblank_rise;
   logic hblank_fall;
   logic vblank_rise;
   logic unused_cen_fall;
   logic unused_vblank_fall;

   logic [WIDTH-1:0]  shadow_val;
   logic [WIDTH-1:0]  active_val;
   logic [CTRL_W-1:0] shadow_ctrl;
   logic [CTRL_W-1:0] active_ctrl;
   logic [CTRL_W-1:0] active_ctrl_nxt;

   logic [1:0] state;
   logic [1:0] state_nxt;

   // cen idles high after reset so a held-high cen is not mistaken for an edge
   edge_det_sync #(.RESET_LEVEL(1'b1)) u_cen_edge (
      .clk   (clk),
      .Reset (Reset),
      .din   (cen),
      .rise  (cen_rise),
      .fall  (unused_cen_fall)
   );

   edge_det_sync #(.RESET_LEVEL(1'b0)) u_hblank_edge (
      .clk   (clk),
      .Reset (Reset),
      .din   (hblank),
      .rise  (hblank_rise),
      .fall  (hblank_fall)
   );

   edge_det_sync #(.RESET_LEVEL(1'b0)) u_vblank_edge (
      .clk   (clk),
      .Reset (Reset),
      .din   (vblank),
      .rise  (vblank_rise),
      .fall  (unused_vblank_fall)
   );

   // CPU writes only touch shadow; a write coinciding with the vblank transfer waits a frame
   always_ff @(posedge clk) begin
      if (Reset) begin
         shadow_val  <= '0;
         shadow_ctrl <= ctrl_reset_val();
      end else begin
         if (cpu_wr_lo)
            shadow_val[7:0] <= cpu_din;
         if (cpu_wr_hi)
            shadow_val[WIDTH-1:8] <= cpu_din[WIDTH-9:0];
         if (cpu_wr_ctrl)
            shadow_ctrl <= cpu_din[CTRL_W-1:0];
      end
   end

   // Shadow-to-active transfer at vblank start; takes shadow contents from before this edge
   always_ff @(posedge clk) begin
      if (Reset) begin
         active_val  <= '0;
         active_ctrl <= ctrl_reset_val();
      end else if (vblank_rise) begin
         active_val  <= shadow_val;
         active_ctrl <= shadow_ctrl;
      end
   end

   // The enables must see the ctrl value that is active after this edge
   assign active_ctrl_nxt = vblank_rise ? shadow_ctrl : active_ctrl;

   // Next-state: load is armed by a line start and committed by the next cen rise
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (hblank_fall)
               state_nxt = ST_PEND;
         end
         ST_PEND: begin
            if (cen_rise)
               state_nxt = ST_COUNT;
         end
         ST_COUNT: begin
            // A fall here means the blank was missed; start a fresh load
            if (hblank_fall)
               state_nxt = ST_PEND;
            else if (hblank_rise)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and registered counter controls, derived from the state being entered
   always_ff @(posedge clk) begin
      if (Reset) begin
         state  <= ST_IDLE;
         load_n <= 1'b1;
         ent_n  <= 1'b1;
         enp_n  <= 1'b1;
      end else begin
         state  <= state_nxt;
         load_n <= (state_nxt != ST_PEND);
         ent_n  <= (state_nxt != ST_COUNT);
         enp_n  <= (state_nxt == ST_COUNT) ? active_ctrl_nxt[FREEZE_BIT] : 1'b1;
      end
   end

   assign P         = active_val;
   assign direction = active_ctrl[DIR_BIT];

endmodule

// File: tb/tb_scroll_load_ctrl.sv
module tb_scroll_load_ctrl;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        cen = 1'b0;
   logic        hblank = 1'b1;
   logic        vblank = 1'b0;
   logic [7:0]  cpu_din = 8'h00;
   logic        cpu_wr_lo = 1'b0;
   logic        cpu_wr_hi = 1'b0;
   logic        cpu_wr_ctrl = 1'b0;
   logic [11:0] P;
   logic        load_n;
   logic        enp_n;
   logic        ent_n;
   logic        direction;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   scroll_load_ctrl #(.WIDTH(12)) dut (
      .clk         (clk),
      .Reset       (Reset),
      .cen         (cen),
      .hblank      (hblank),
      .vblank      (vblank),
      .cpu_din     (cpu_din),
      .cpu_wr_lo   (cpu_wr_lo),
      .cpu_wr_hi   (cpu_wr_hi),
      .cpu_wr_ctrl (cpu_wr_ctrl),
      .P           (P),
      .load_n      (load_n),
      .enp_n       (enp_n),
      .ent_n       (ent_n),
      .direction   (direction)
   );

   // ---------------- reference model ----------------
   // Phase of the line: 0 waiting for a line start, 1 load pending, 2 counting.
   int          m_phase;
   logic [11:0] m_sh_val, m_ac_val;
   logic        m_sh_dir, m_sh_frz, m_ac_dir, m_ac_frz;
   // Input samples taken at the previous two clock edges
   logic        c1, c2, h1, h2, v1, v2;
   bit          cen_auto = 1'b0;
   int          cen_cnt = 0;

   task automatic model_edge();
      bit cr, hf, hr, vr;
      if (Reset) begin
         m_phase  = 0;
         m_sh_val = '0; m_ac_val = '0;
         m_sh_dir = 1'b1; m_sh_frz = 1'b0;
         m_ac_dir = 1'b1; m_ac_frz = 1'b0;
         c1 = 1'b1; c2 = 1'b1;
         h1 = 1'b0; h2 = 1'b0;
         v1 = 1'b0; v2 = 1'b0;
      end else begin
         cr = c1 && !c2;
         hf = !h1 && h2;
         hr = h1 && !h2;
         vr = v1 && !v2;
         if (vr) begin
            m_ac_val = m_sh_val;
            m_ac_dir = m_sh_dir;
            m_ac_frz = m_sh_frz;
         end
         if (cpu_wr_lo)   m_sh_val = {m_sh_val[11:8], cpu_din};
         if (cpu_wr_hi)   m_sh_val = {cpu_din[3:0], m_sh_val[7:0]};
         if (cpu_wr_ctrl) begin
            m_sh_dir = cpu_din[0];
            m_sh_frz = cpu_din[1];
         end
         if (m_phase == 0 && hf)      m_phase = 1;
         else if (m_phase == 1 && cr) m_phase = 2;
         else if (m_phase == 2 && hf) m_phase = 1;
         else if (m_phase == 2 && hr) m_phase = 0;
         c2 = c1; c1 = cen;
         h2 = h1; h1 = hblank;
         v2 = v1; v1 = vblank;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (check %0d, t=%0t)", tag, obs, exp, checks, $time);
      end
   endtask

   // One clock: advance model at the edge, compare #1 later, then move cen
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("load_n",    32'(load_n),    32'(m_phase != 1));
      chk("ent_n",     32'(ent_n),     32'(m_phase != 2));
      chk("enp_n",     32'(enp_n),     32'((m_phase == 2) ? m_ac_frz : 1'b1));
      chk("direction", 32'(direction), 32'(m_ac_dir));
      chk("P",         32'(P),         32'(m_ac_val));
      cen_cnt++;
      if (cen_auto) cen = (cen_cnt % 4) < 2;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // kind: 0 lo, 1 hi, 2 ctrl
   task automatic cpu_write(input int kind, input logic [7:0] d);
      cpu_din     = d;
      cpu_wr_lo   = (kind == 0);
      cpu_wr_hi   = (kind == 1);
      cpu_wr_ctrl = (kind == 2);
      step();
      cpu_wr_lo = 1'b0; cpu_wr_hi = 1'b0; cpu_wr_ctrl = 1'b0;
   endtask

   task automatic line(input int active_len, input int blank_len);
      hblank = 1'b0;
      steps(active_len);
      hblank = 1'b1;
      steps(blank_len);
   endtask

   task automatic vblank_pulse();
      vblank = 1'b1;
      steps(4);
      vblank = 1'b0;
      steps(3);
   endtask

   initial begin
      int seen;

      // Reset
      model_edge();
      steps(3);
      Reset = 1'b0;
      chk("rst_load_n", 32'(load_n), 32'd1);
      chk("rst_ent_n",  32'(ent_n),  32'd1);
      chk("rst_enp_n",  32'(enp_n),  32'd1);
      chk("rst_dir",    32'(direction), 32'd1);
      chk("rst_P",      32'(P), 32'h000);
      cen_auto = 1'b1;
      steps(4);

      // First line: load_n low 2 cycles after the fall
      hblank = 1'b0;
      step();
      chk("line1_load_t1", 32'(load_n), 32'd1);
      step();
      chk("line1_load_t2", 32'(load_n), 32'd0);
      chk("line1_P", 32'(P), 32'h000);
      steps(20);
      chk("line1_count_ent", 32'(ent_n), 32'd0);
      chk("line1_count_enp", 32'(enp_n), 32'd0);
      hblank = 1'b1;
      steps(3);
      chk("line1_blank_ent", 32'(ent_n), 32'd1);
      chk("line1_blank_enp", 32'(enp_n), 32'd1);

      // Write 0x234 outside vblank; only visible after the transfer
      cpu_write(0, 8'h34);
      cpu_write(1, 8'h02);
      steps(2);
      chk("no_xfer_P", 32'(P), 32'h000);
      vblank = 1'b1;
      step();
      chk("xfer_detect_P", 32'(P), 32'h000);
      step();
      chk("xfer_P", 32'(P), 32'h234);
      vblank = 1'b0;
      steps(3);
      line(16, 6);

      // Write in the same cycle as the transfer: old shadow moves, new waits a frame
      cpu_write(0, 8'h55);
      cpu_write(1, 8'h01);
      vblank = 1'b1;
      step();
      cpu_write(1, 8'h03);
      chk("coincide_P", 32'(P), 32'h155);
      vblank = 1'b0;
      steps(4);
      chk("coincide_hold_P", 32'(P), 32'h155);
      vblank_pulse();
      chk("coincide_next_P", 32'(P), 32'h355);

      // Freeze with direction down
      cpu_write(2, 8'h02);
      vblank_pulse();
      chk("frz_dir", 32'(direction), 32'd0);
      hblank = 1'b0;
      seen = 0;
      for (int i = 0; i < 30 && seen == 0; i++) begin
         step();
         if (ent_n == 1'b0) seen = 1;
      end
      chk("frz_ent_n", 32'(ent_n), 32'd0);
      chk("frz_enp_n", 32'(enp_n), 32'd1);
      steps(4);
      hblank = 1'b1;
      steps(4);
      cpu_write(2, 8'h00);
      vblank_pulse();
      chk("ctrl0_dir", 32'(direction), 32'd0);
      line(12, 4);

      // Reset while a load is pending
      cen_auto = 1'b0;
      cen = 1'b0;
      hblank = 1'b0;
      steps(3);
      chk("pend_load_n", 32'(load_n), 32'd0);
      Reset = 1'b1;
      model_edge();
      step();
      Reset = 1'b0;
      chk("rstpend_load_n", 32'(load_n), 32'd1);
      chk("rstpend_ent_n",  32'(ent_n),  32'd1);
      chk("rstpend_enp_n",  32'(enp_n),  32'd1);
      chk("rstpend_P",      32'(P), 32'h000);
      hblank = 1'b1;
      cen_auto = 1'b1;
      steps(4);
      line(14, 5);

      // cen held high across the line start: no count until a fresh rise
      cen_auto = 1'b0;
      cen = 1'b1;
      steps(3);
      hblank = 1'b0;
      steps(10);
      chk("cenhigh_load_n", 32'(load_n), 32'd0);
      cen = 1'b0;
      step();
      cen = 1'b1;
      step();
      chk("cenrise_load_n", 32'(load_n), 32'd0);
      step();
      chk("cenrise_after_load_n", 32'(load_n), 32'd1);
      chk("cenrise_after_ent_n",  32'(ent_n),  32'd0);
      hblank = 1'b1;
      steps(4);

      // Randomized lines, writes and vblank transfers
      cen_auto = 1'b1;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            cpu_din     = 8'($urandom);
            cpu_wr_lo   = $urandom_range(0, 1) == 1;
            cpu_wr_hi   = $urandom_range(0, 1) == 1;
            cpu_wr_ctrl = $urandom_range(0, 2) == 0;
            step();
            cpu_wr_lo = 1'b0; cpu_wr_hi = 1'b0; cpu_wr_ctrl = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) begin
            vblank = 1'b1;
            steps($urandom_range(1, 5));
            vblank = 1'b0;
         end
         if ($urandom_range(0, 4) == 0) begin
            cen_auto = 1'b0;
            cen = 1'($urandom_range(0, 1));
         end else begin
            cen_auto = 1'b1;
         end
         line($urandom_range(3, 30), $urandom_range(2, 10));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
